// File: rtl/hpf_dc_block.sv
// First-order DC-blocking high-pass filter: out = x - LPF(x), with a two-stage
// valid/ready pipeline, sticky saturation flag and a settle indicator.
module hpf_dc_block #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned SH       = 3,
  parameter int unsigned SETTLE_N = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sat_flag,
  output logic              settled
);

  localparam int unsigned AccW  = DATA_W + SH + 2;
  localparam int unsigned DiffW = DATA_W + 1;
  localparam logic [15:0] SettleMax = 16'(SETTLE_N);

  localparam logic [DATA_W-1:0] OutMax = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] OutMin = {1'b1, {(DATA_W-1){1'b0}}};

  // Stage 1 state
  logic signed [AccW-1:0]   acc_q, acc_d;
  logic        [DATA_W-1:0] xs_q, xs_d;
  logic                     s1_valid_q, s1_valid_d;

  // Stage 2 / output state
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              sat_q, sat_d;

  logic [15:0] cnt_q, cnt_d;
  logic        settled_q, settled_d;

  logic flush;
  logic in_fire;
  logic s2_fire;

  assign flush    = !rst_n || clear;
  assign in_ready = !flush && (!s1_valid_q || !out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign s2_fire  = s1_valid_q && (!out_valid_q || out_ready);

  // Stage 1: accumulator recurrence. xs_q doubles as x[n-1] for the next sample.
  logic signed [AccW-1:0] x_ext;
  logic signed [AccW-1:0] x1_ext;
  logic signed [AccW-1:0] leak;

  always_comb begin
    x_ext      = {{(AccW-DATA_W){in_data[DATA_W-1]}}, in_data};
    x1_ext     = {{(AccW-DATA_W){xs_q[DATA_W-1]}}, xs_q};
    leak       = acc_q >>> SH;
    acc_d      = acc_q;
    xs_d       = xs_q;
    s1_valid_d = s1_valid_q;
    if (in_fire) begin
      acc_d      = acc_q + x_ext + x1_ext - leak;
      xs_d       = in_data;
      s1_valid_d = 1'b1;
    end else if (s2_fire) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2: subtract the low-pass estimate and clamp to the output range.
  logic signed [DiffW-1:0] lp;
  logic signed [DiffW-1:0] xs_ext;
  logic signed [DiffW-1:0] diff;
  logic                    diff_ovf;
  logic [DATA_W-1:0]       diff_clamped;

  always_comb begin
    lp       = DiffW'(acc_q >>> (SH + 1));
    xs_ext   = {xs_q[DATA_W-1], xs_q};
    diff     = xs_ext - lp;
    diff_ovf = diff[DiffW-1] ^ diff[DiffW-2];
    if (!diff_ovf) begin
      diff_clamped = diff[DATA_W-1:0];
    end else if (diff[DiffW-1]) begin
      diff_clamped = OutMin;
    end else begin
      diff_clamped = OutMax;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sat_d       = sat_q;
    if (s2_fire) begin
      out_data_d  = diff_clamped;
      out_valid_d = 1'b1;
      sat_d       = sat_q | diff_ovf;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (in_fire && (cnt_q != SettleMax)) begin
      cnt_d = cnt_q + 16'd1;
    end
    settled_d = (cnt_d == SettleMax);
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      acc_q       <= '0;
      xs_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
      settled_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      xs_q        <= xs_d;
      s1_valid_q  <= s1_valid_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      cnt_q       <= cnt_d;
      settled_q   <= settled_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_q;
  assign settled   = settled_q;

endmodule

// File: tb/tb_hpf_dc_block.sv
// Directed bench for hpf_dc_block: DC step, saturation, clear, reset, backpressure
// and full-rate streaming, checked against hand values and a reference recurrence.
module tb_hpf_dc_block;

  localparam int unsigned DW      = 24;
  localparam int unsigned SettleN = 64;

  logic          clk = 1'b0;
  logic          rst_n, clear, in_valid, in_ready, out_valid, out_ready, sat_flag, settled;
  logic [DW-1:0] in_data, out_data;

  int n_vec = 0;
  int n_err = 0;

  hpf_dc_block #(
    .DATA_W  (DW),
    .SH      (3),
    .SETTLE_N(SettleN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sat_flag (sat_flag),
    .settled  (settled)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference filter, written with explicit floor division.
  longint m_acc, m_x1;

  function automatic longint fdiv(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic longint model_step(input longint x);
    longint d;
    m_acc = m_acc + x + m_x1 - fdiv(m_acc, 8);
    m_x1  = x;
    d     = x - fdiv(m_acc, 16);
    if (d > 64'sd8388607)  d = 64'sd8388607;
    if (d < -64'sd8388608) d = -64'sd8388608;
    return d;
  endfunction

  longint exp_q[$];
  longint got_q[$];
  int     acc_cyc_q[$];
  int     got_cyc_q[$];
  int     cyc = 0;
  int     n_in = 0;
  int     n_out = 0;
  int     n_since_clr = 0;
  bit     chk_settle = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (out_valid && out_ready) begin
      got_q.push_back(longint'($signed(out_data)));
      got_cyc_q.push_back(cyc);
      n_out++;
    end
  end

  // A stalled output must hold across the edge.
  always @(posedge clk) begin
    logic [DW-1:0] held;
    if (rst_n && !clear && out_valid && !out_ready) begin
      held = out_data;
      #1;
      check_val("stall_hold_valid", out_valid, 1);
      check_val("stall_hold_data", $signed(out_data), $signed(held));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_book();
    n_in        = n_out;
    n_since_clr = 0;
    m_acc       = 0;
    m_x1        = 0;
    exp_q.delete();
    got_q.delete();
    acc_cyc_q.delete();
    got_cyc_q.delete();
  endtask

  // mode 0: out_ready=1, 1: random out_ready, 2: out_ready=0
  task automatic push(input longint x, input int mode);
    int guard = 0;
    bit done  = 1'b0;
    in_data  = x[DW-1:0];
    in_valid = 1'b1;
    while (!done) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      #1;
      check_val("in_ready", in_ready, ((n_in - n_out) == 2 && !out_ready) ? 0 : 1);
      if (in_ready) begin
        done = 1'b1;
        n_in++;
        n_since_clr++;
        exp_q.push_back(model_step(x));
        acc_cyc_q.push_back(cyc + 1);
      end
      tick();
      if (done && chk_settle && n_since_clr >= SettleN - 1 && n_since_clr <= SettleN)
        check_val("settled_edge", settled, (n_since_clr == SettleN) ? 1 : 0);
      if (!done) begin
        guard++;
        if (guard > 50) begin
          check_val("in_ready_timeout", in_ready, 1);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (n_out < n_in && guard < 20) begin
      tick();
      guard++;
    end
    check_val("drain_count", n_out, n_in);
  endtask

  task automatic compare_q(input string tag);
    check_val({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_val($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic do_clear();
    clear    = 1'b1;
    in_valid = 1'b0;
    tick();
    clear = 1'b0;
    reset_book();
  endtask

  initial begin
    int     viol;
    longint maxabs;
    int     n_out0;
    longint bp_vec[10];

    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    reset_book();
    tick();
    tick();
    check_val("rst_out_data", $signed(out_data), 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_sat_flag", sat_flag, 0);
    check_val("rst_settled", settled, 0);
    check_val("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    check_val("post_rst_in_ready", in_ready, 1);

    // DC step of 1000
    chk_settle = 1'b1;
    for (int i = 0; i < 220; i++) push(1000, 0);
    chk_settle = 1'b0;
    drain();
    if (got_q.size() >= 220) begin
      check_val("dc_out0", got_q[0], 938);
      check_val("dc_out1", got_q[1], 821);
      check_val("dc_out2", got_q[2], 718);
      viol   = 0;
      maxabs = 0;
      for (int i = 1; i < 220; i++) if (got_q[i] > got_q[i-1]) viol++;
      for (int i = 200; i < 220; i++) begin
        if (got_q[i] > maxabs)  maxabs = got_q[i];
        if (-got_q[i] > maxabs) maxabs = -got_q[i];
      end
      check_val("dc_monotonic_violations", viol, 0);
      check_val("dc_residual_le16", (maxabs <= 16) ? 1 : 0, 1);
    end
    compare_q("dc");

    // Saturation
    do_clear();
    push(-8388608, 0);
    push(8388607, 0);
    check_val("sat_out0_valid", out_valid, 1);
    check_val("sat_out0", $signed(out_data), -7864320);
    check_val("sat_flag0", sat_flag, 0);
    tick();
    check_val("sat_out1", $signed(out_data), 8388607);
    check_val("sat_flag1", sat_flag, 1);
    chk_settle = 1'b1;
    for (int i = 0; i < 62; i++) push(0, 0);
    chk_settle = 1'b0;
    drain();
    check_val("sat_sticky", sat_flag, 1);
    check_val("sat_settled", settled, 1);
    compare_q("sat");

    // clear with two samples in flight
    push(1000, 2);
    push(2000, 2);
    check_val("clr_pre_out_valid", out_valid, 1);
    check_val("clr_pre_in_ready", in_ready, 0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 24'd7777;
    #1;
    check_val("clr_in_ready", in_ready, 0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    reset_book();
    check_val("clr_out_valid", out_valid, 0);
    check_val("clr_out_data", $signed(out_data), 0);
    check_val("clr_sat_flag", sat_flag, 0);
    check_val("clr_settled", settled, 0);
    push(1000, 0);
    tick();
    check_val("clr_first_valid", out_valid, 1);
    check_val("clr_first_out", $signed(out_data), 938);
    drain();
    compare_q("clr");

    // Backpressure
    do_clear();
    bp_vec = '{1000, -2000, 3000, 4000, -5000, 123456, -654321, 0, 77, -8388608};
    for (int i = 0; i < 10; i++) push(bp_vec[i], 1);
    drain();
    compare_q("bp");

    // Reset during a stall
    do_clear();
    push(500, 2);
    tick();
    check_val("rstmid_stall_valid", out_valid, 1);
    tick();
    rst_n = 1'b0;
    tick();
    check_val("rstmid_out_valid", out_valid, 0);
    check_val("rstmid_out_data", $signed(out_data), 0);
    check_val("rstmid_sat_flag", sat_flag, 0);
    check_val("rstmid_settled", settled, 0);
    check_val("rstmid_in_ready", in_ready, 0);
    rst_n = 1'b1;
    reset_book();
    n_out0    = n_out;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_val("rstmid_no_delivery", n_out, n_out0);
    check_val("rstmid_idle_valid", out_valid, 0);

    // Full-rate streaming
    do_clear();
    for (int i = 0; i < 1000; i++) push(longint'((i * 7919) % 20001) - 10000, 0);
    drain();
    compare_q("tput");
    for (int i = 0; i < acc_cyc_q.size() && i < got_cyc_q.size(); i++)
      check_val($sformatf("tput_latency[%0d]", i), got_cyc_q[i] - acc_cyc_q[i], 2);
    if (acc_cyc_q.size() == 1000)
      check_val("tput_span", acc_cyc_q[999] - acc_cyc_q[0], 999);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
